// File: rtl/rf_pkg.sv
// Shared definitions for the dual-write-port register file: default widths,
// index/data typedefs and the younger-lane selection rule.
package rf_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_AW   = 5;
  localparam int NUM_REGS = 2 ** DEF_AW;

  typedef logic [DEF_AW-1:0]   reg_idx_t;
  typedef logic [DEF_XLEN-1:0] xword_t;

  typedef enum logic {
    LANE1 = 1'b0,
    LANE2 = 1'b1
  } lane_t;

  // The younger lane wins any same-register conflict.
  function automatic lane_t younger_lane(input logic wb2_older);
    return wb2_older ? LANE1 : LANE2;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: array mux with x0 zeroing; forwards in-flight writes when
// RF_BYPASS_EN is defined.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] regs [2**AW],
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_rd,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            wr2_en,
  input  logic [AW-1:0]   wr2_rd,
  input  logic [XLEN-1:0] wr2_data,
  input  logic            wb2_older,
  output logic [XLEN-1:0] data
);

`ifdef RF_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wr1_en && (wr1_rd == idx);
  assign hit2 = wr2_en && (wr2_rd == idx);

  // Write enables arrive already qualified by ACT and rd != 0.
  always_comb begin
    data = '0;
    if (hit1 && hit2) begin
      data = (younger_lane(wb2_older) == LANE1) ? wr1_data : wr2_data;
    end else if (hit1) begin
      data = wr1_data;
    end else if (hit2) begin
      data = wr2_data;
    end else if (idx != '0) begin
      data = regs[idx];
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr1_en, wr1_rd, wr1_data, wr2_en, wr2_rd, wr2_data, wb2_older};

  always_comb begin
    data = '0;
    if (idx != '0) begin
      data = regs[idx];
    end
  end
`endif

endmodule

// File: rtl/regfile_dual_wb_t.sv
// Dual-write, quad-read integer register file with hardwired x0 and a sticky
// write-write collision flag. Define RF_BYPASS_EN for same-cycle forwarding.
module regfile_dual_wb_t
  import rf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ACT,
  input  logic            wb1_wten,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            wb2_wten,
  input  logic [AW-1:0]   wb2_rd,
  input  logic [XLEN-1:0] wb2_data,
  input  logic            wb2_older,
  input  logic [AW-1:0]   rdA_rs1,
  input  logic [AW-1:0]   rdA_rs2,
  input  logic [AW-1:0]   rdB_rs1,
  input  logic [AW-1:0]   rdB_rs2,
  output logic [XLEN-1:0] rdA_rs1_data,
  output logic [XLEN-1:0] rdA_rs2_data,
  output logic [XLEN-1:0] rdB_rs1_data,
  output logic [XLEN-1:0] rdB_rs2_data,
  output logic            rf_wwcol
);

  localparam int NREGS = 2 ** AW;

  logic [XLEN-1:0] regs_reg [1:NREGS-1];
  logic [XLEN-1:0] rf_view  [NREGS];
  logic            wwcol_reg;

  logic wr1_en;
  logic wr2_en;
  logic collision;
  logic lane1_wins;

  assign wr1_en     = ACT && wb1_wten && (wb1_rd != '0);
  assign wr2_en     = ACT && wb2_wten && (wb2_rd != '0);
  assign collision  = wr1_en && wr2_en && (wb1_rd == wb2_rd);
  assign lane1_wins = (younger_lane(wb2_older) == LANE1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
      wwcol_reg <= 1'b0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (collision && (wb1_rd == AW'(i))) begin
          regs_reg[i] <= lane1_wins ? wb1_data : wb2_data;
        end else if (wr1_en && (wb1_rd == AW'(i))) begin
          regs_reg[i] <= wb1_data;
        end else if (wr2_en && (wb2_rd == AW'(i))) begin
          regs_reg[i] <= wb2_data;
        end
      end
      if (collision) begin
        wwcol_reg <= 1'b1;
      end
    end
  end

  assign rf_wwcol = wwcol_reg;

  // Full-size view so read ports can index 0..NREGS-1 with x0 pinned to zero.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_view
      if (gi == 0) begin : g_zero
        assign rf_view[gi] = '0;
      end else begin : g_reg
        assign rf_view[gi] = regs_reg[gi];
      end
    end
  endgenerate

  logic [AW-1:0]   rd_idx  [4];
  logic [XLEN-1:0] rd_data [4];

  assign rd_idx[0] = rdA_rs1;
  assign rd_idx[1] = rdA_rs2;
  assign rd_idx[2] = rdB_rs1;
  assign rd_idx[3] = rdB_rs2;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      rf_read_port #(
        .XLEN(XLEN),
        .AW  (AW)
      ) u_port (
        .idx      (rd_idx[gi]),
        .regs     (rf_view),
        .wr1_en   (wr1_en),
        .wr1_rd   (wb1_rd),
        .wr1_data (wb1_data),
        .wr2_en   (wr2_en),
        .wr2_rd   (wb2_rd),
        .wr2_data (wb2_data),
        .wb2_older(wb2_older),
        .data     (rd_data[gi])
      );
    end
  endgenerate

  assign rdA_rs1_data = rd_data[0];
  assign rdA_rs2_data = rd_data[1];
  assign rdB_rs1_data = rd_data[2];
  assign rdB_rs2_data = rd_data[3];

endmodule

// File: tb/tb_regfile_dual_wb_t.sv
// Directed bench for regfile_dual_wb_t; expectations follow RF_BYPASS_EN when defined.
module tb_regfile_dual_wb_t;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            CLK;
  logic            RST;
  logic            ACT;
  logic            wb1_wten;
  logic [AW-1:0]   wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic            wb2_wten;
  logic [AW-1:0]   wb2_rd;
  logic [XLEN-1:0] wb2_data;
  logic            wb2_older;
  logic [AW-1:0]   rdA_rs1;
  logic [AW-1:0]   rdA_rs2;
  logic [AW-1:0]   rdB_rs1;
  logic [AW-1:0]   rdB_rs2;
  logic [XLEN-1:0] rdA_rs1_data;
  logic [XLEN-1:0] rdA_rs2_data;
  logic [XLEN-1:0] rdB_rs1_data;
  logic [XLEN-1:0] rdB_rs2_data;
  logic            rf_wwcol;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_dual_wb_t #(.XLEN(XLEN), .AW(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ACT         (ACT),
    .wb1_wten    (wb1_wten),
    .wb1_rd      (wb1_rd),
    .wb1_data    (wb1_data),
    .wb2_wten    (wb2_wten),
    .wb2_rd      (wb2_rd),
    .wb2_data    (wb2_data),
    .wb2_older   (wb2_older),
    .rdA_rs1     (rdA_rs1),
    .rdA_rs2     (rdA_rs2),
    .rdB_rs1     (rdB_rs1),
    .rdB_rs2     (rdB_rs2),
    .rdA_rs1_data(rdA_rs1_data),
    .rdA_rs2_data(rdA_rs2_data),
    .rdB_rs1_data(rdB_rs1_data),
    .rdB_rs2_data(rdB_rs2_data),
    .rf_wwcol    (rf_wwcol)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [AW-1:0] b1, input logic [AW-1:0] b2);
    rdA_rs1 = a1;
    rdA_rs2 = a2;
    rdB_rs1 = b1;
    rdB_rs2 = b2;
    #1;
  endtask

  task automatic idle_writes();
    wb1_wten = 1'b0;
    wb2_wten = 1'b0;
    wb1_rd   = '0;
    wb2_rd   = '0;
    wb1_data = '0;
    wb2_data = '0;
  endtask

  initial begin
    RST = 1'b1;
    ACT = 1'b0;
    wb2_older = 1'b0;
    idle_writes();
    rdA_rs1 = '0; rdA_rs2 = '0; rdB_rs1 = '0; rdB_rs2 = '0;

    // Reset, then every index on every port reads zero
    tick();
    RST = 1'b0;
    ACT = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_reads(AW'(i), AW'(31 - i), AW'(i), AW'(31 - i));
      chk("rst_a1", rdA_rs1_data, 32'h0);
      chk("rst_a2", rdA_rs2_data, 32'h0);
      chk("rst_b1", rdB_rs1_data, 32'h0);
      chk("rst_b2", rdB_rs2_data, 32'h0);
    end
    chk("rst_wwcol", {31'b0, rf_wwcol}, 32'h0);

    // Dual write to distinct registers
    wb1_wten = 1'b1; wb1_rd = 5'd5; wb1_data = 32'h1111_1111;
    wb2_wten = 1'b1; wb2_rd = 5'd6; wb2_data = 32'h2222_2222;
    tick();
    idle_writes();
    set_reads(5'd5, 5'd6, 5'd5, 5'd6);
    chk("dual_a1_r5", rdA_rs1_data, 32'h1111_1111);
    chk("dual_a2_r6", rdA_rs2_data, 32'h2222_2222);
    chk("dual_b1_r5", rdB_rs1_data, 32'h1111_1111);
    chk("dual_b2_r6", rdB_rs2_data, 32'h2222_2222);
    chk("dual_wwcol", {31'b0, rf_wwcol}, 32'h0);

    // Write to x0 is discarded
    wb1_wten = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hDEAD_BEEF;
    set_reads(5'd0, 5'd0, 5'd5, 5'd0);
    chk("x0_same_cyc", rdA_rs1_data, 32'h0);
    tick();
    idle_writes();
    set_reads(5'd0, 5'd5, 5'd6, 5'd0);
    chk("x0_a1", rdA_rs1_data, 32'h0);
    chk("x0_a2_r5", rdA_rs2_data, 32'h1111_1111);
    chk("x0_b1_r6", rdB_rs1_data, 32'h2222_2222);
    chk("x0_wwcol", {31'b0, rf_wwcol}, 32'h0);

    // Write-to-read latency on lane 2, rd=9
    wb2_wten = 1'b1; wb2_rd = 5'd9; wb2_data = 32'h1234_5678;
    set_reads(5'd0, 5'd9, 5'd0, 5'd0);
`ifdef RF_BYPASS_EN
    chk("byp_same_cyc", rdA_rs2_data, 32'h1234_5678);
`else
    chk("byp_same_cyc", rdA_rs2_data, 32'h0);
`endif
    tick();
    idle_writes();
    #1;
    chk("byp_next_cyc", rdA_rs2_data, 32'h1234_5678);

    // ACT=0 blocks both the write and any forwarding
    ACT = 1'b0;
    wb1_wten = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h0000_0005;
    set_reads(5'd3, 5'd0, 5'd0, 5'd0);
    chk("act0_same_cyc", rdA_rs1_data, 32'h0);
    tick();
    idle_writes();
    ACT = 1'b1;
    #1;
    chk("act0_r3", rdA_rs1_data, 32'h0);

    // Collision on r7, lane 2 older -> lane 1 wins
    wb2_older = 1'b1;
    wb1_wten = 1'b1; wb1_rd = 5'd7; wb1_data = 32'hAAAA_0000;
    wb2_wten = 1'b1; wb2_rd = 5'd7; wb2_data = 32'h0000_BBBB;
    set_reads(5'd0, 5'd0, 5'd7, 5'd0);
`ifdef RF_BYPASS_EN
    chk("col7_same_cyc", rdB_rs1_data, 32'hAAAA_0000);
`else
    chk("col7_same_cyc", rdB_rs1_data, 32'h0);
`endif
    chk("col7_pre_flag", {31'b0, rf_wwcol}, 32'h0);
    tick();
    idle_writes();
    #1;
    chk("col7_r7", rdB_rs1_data, 32'hAAAA_0000);
    chk("col7_flag", {31'b0, rf_wwcol}, 32'h1);

    // Collision on r8, lane 1 older -> lane 2 wins
    wb2_older = 1'b0;
    wb1_wten = 1'b1; wb1_rd = 5'd8; wb1_data = 32'hCCCC_0001;
    wb2_wten = 1'b1; wb2_rd = 5'd8; wb2_data = 32'h0002_DDDD;
    tick();
    idle_writes();
    set_reads(5'd0, 5'd0, 5'd0, 5'd8);
    chk("col8_r8", rdB_rs2_data, 32'h0002_DDDD);

    // Flag is sticky across idle cycles
    tick();
    tick();
    chk("flag_sticky", {31'b0, rf_wwcol}, 32'h1);

    // Reset in the same cycle as a write to r4
    RST = 1'b1;
    wb1_wten = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h4444_4444;
    tick();
    RST = 1'b0;
    idle_writes();
    set_reads(5'd4, 5'd7, 5'd5, 5'd9);
    chk("rst_r4", rdA_rs1_data, 32'h0);
    chk("rst_r7", rdA_rs2_data, 32'h0);
    chk("rst_r5", rdB_rs1_data, 32'h0);
    chk("rst_r9", rdB_rs2_data, 32'h0);
    chk("rst_flag", {31'b0, rf_wwcol}, 32'h0);

    // Highest register writes and reads back
    wb2_wten = 1'b1; wb2_rd = 5'd31; wb2_data = 32'hF0F0_0F0F;
    tick();
    idle_writes();
    set_reads(5'd31, 5'd0, 5'd0, 5'd30);
    chk("r31", rdA_rs1_data, 32'hF0F0_0F0F);
    chk("r30", rdB_rs2_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
